// File: rtl/crc16_pkg.sv
// Shared CRC-16 (0x1021) constants, checker state encoding and the parallel
// one-word update function.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    DISCARD = 2'd2
  } crc_chk_state_e;

  // The update is linear, so the data word is folded into the register first
  // and then sixteen zero bits are shifted through the feedback.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                             input logic [15:0] data);
    logic [15:0] c;
    c = crc ^ data;
    for (int i = 0; i < 16; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_next_comb.sv
// Combinational wrapper around crc16_next so the update equations can be
// synthesised or formally checked on their own.
module crc16_next_comb
  import crc16_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [15:0] i_data,
  output logic [15:0] o_crc
);

  assign o_crc = crc16_next(i_crc, i_data);

endmodule

// File: rtl/crc16_frame_checker.sv
// Receive-side CRC-16 frame checker: forwards the word stream through one
// register stage and flags CRC/length status on the final (CRC) beat.
// Optional frame/error statistics counters are built when CRC_CHECK_STATS_EN is defined.
//
// state   | meaning
// IDLE    | waiting for the first beat of a frame
// ACTIVE  | accumulating CRC over payload words
// DISCARD | payload overran MAX_WORDS; forward until the CRC beat
module crc16_frame_checker
  import crc16_pkg::*;
#(
  parameter int          MAX_WORDS = 64,
  parameter logic [15:0] CRC_INIT  = CRC16_INIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        out_crc_ok,
  output logic        out_crc_err,
  output logic        out_len_err,
`ifdef CRC_CHECK_STATS_EN
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
`endif
  output logic [15:0] crc_calc
);

  localparam logic [15:0] MAX_W = MAX_WORDS[15:0];

  crc_chk_state_e r_state, w_state_nxt;
  logic [15:0]    r_crc, w_crc_nxt, w_crc_base, w_crc_step;
  logic [15:0]    r_word_cnt, w_word_cnt_nxt;
  logic           r_rst_done;
  logic           r_out_valid, r_out_last, r_out_ok, r_out_err, r_out_len;
  logic [15:0]    r_out_data;
  logic           w_in_fire, w_out_fire;
  logic           w_ok, w_err, w_len;

  assign in_ready   = r_rst_done & (out_ready | ~r_out_valid);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // A frame's first word always starts from CRC_INIT, even back-to-back.
  assign w_crc_base = (r_state == IDLE) ? CRC_INIT : r_crc;

  crc16_next_comb u_crc_next (
    .i_crc  (w_crc_base),
    .i_data (in_data),
    .o_crc  (w_crc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_crc      <= CRC_INIT;
      r_word_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_crc      <= w_crc_nxt;
      r_word_cnt <= w_word_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_crc_nxt      = r_crc;
    w_word_cnt_nxt = r_word_cnt;
    w_ok           = 1'b0;
    w_err          = 1'b0;
    w_len          = 1'b0;
    if (w_in_fire) begin
      case (r_state)
        IDLE: begin
          if (in_last) begin
            w_ok  = (in_data == CRC_INIT);
            w_err = ~w_ok;
          end else begin
            w_crc_nxt      = w_crc_step;
            w_word_cnt_nxt = 16'd1;
            w_state_nxt    = ACTIVE;
          end
        end
        ACTIVE: begin
          if (in_last) begin
            w_ok           = (in_data == r_crc);
            w_err          = ~w_ok;
            w_crc_nxt      = CRC_INIT;
            w_word_cnt_nxt = 16'd0;
            w_state_nxt    = IDLE;
          end else if (r_word_cnt == MAX_W) begin
            w_state_nxt = DISCARD;
          end else begin
            w_crc_nxt      = w_crc_step;
            w_word_cnt_nxt = r_word_cnt + 16'd1;
          end
        end
        DISCARD: begin
          if (in_last) begin
            w_len          = 1'b1;
            w_err          = 1'b1;
            w_crc_nxt      = CRC_INIT;
            w_word_cnt_nxt = 16'd0;
            w_state_nxt    = IDLE;
          end
        end
        default: begin
          w_crc_nxt      = CRC_INIT;
          w_word_cnt_nxt = 16'd0;
          w_state_nxt    = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 16'd0;
      r_out_last  <= 1'b0;
      r_out_ok    <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_len   <= 1'b0;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data;
      r_out_last  <= in_last;
      r_out_ok    <= w_ok;
      r_out_err   <= w_err;
      r_out_len   <= w_len;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign out_crc_ok  = r_out_ok;
  assign out_crc_err = r_out_err;
  assign out_len_err = r_out_len;
  assign crc_calc    = r_crc;

`ifdef CRC_CHECK_STATS_EN
  logic [15:0] r_frame_cnt, r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else if (w_out_fire && r_out_last) begin
      if (r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (r_out_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`else
  logic w_unused;
  assign w_unused = w_out_fire;
`endif

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Scoreboard bench for crc16_frame_checker (MAX_WORDS=4); stats counters are
// checked when CRC_CHECK_STATS_EN is defined.
module tb_crc16_frame_checker;

  localparam int TB_MAX = 4;

  typedef struct packed {
    logic [15:0] d;
    logic        last;
    logic        ok;
    logic        err;
    logic        len;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [15:0] out_data;
  logic        out_crc_ok, out_crc_err, out_len_err;
  logic [15:0] crc_calc;
`ifdef CRC_CHECK_STATS_EN
  logic [15:0] frame_cnt, err_cnt;
`endif

  int          n_chk  = 0;
  int          n_fail = 0;
  bit          rnd_ready = 1'b0;
  beat_t       sb[$];
  logic [15:0] pl[$];

  always #5 clk = ~clk;

  crc16_frame_checker #(.MAX_WORDS(TB_MAX), .CRC_INIT(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_crc_ok  (out_crc_ok),
    .out_crc_err (out_crc_err),
    .out_len_err (out_len_err),
`ifdef CRC_CHECK_STATS_EN
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt),
`endif
    .crc_calc    (crc_calc)
  );

  // Reference: remainder of ((crc ^ data) * x^16) by long division mod 0x11021.
  function automatic logic [15:0] model_step(input logic [15:0] c, input logic [15:0] d);
    logic [31:0] r;
    r = {c ^ d, 16'h0000};
    for (int i = 31; i >= 16; i--) begin
      if (r[i]) r = r ^ (32'h0001_1021 << (i - 16));
    end
    return r[15:0];
  endfunction

  // Scoreboard monitor: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid && out_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: got data=%h last=%b, nothing expected", out_data, out_last);
      end else begin
        e = sb.pop_front();
        if ({out_data, out_last, out_crc_ok, out_crc_err, out_len_err} !== e) begin
          n_fail++;
          $display("FAIL sb_beat: got d=%h l=%b ok=%b err=%b len=%b, want d=%h l=%b ok=%b err=%b len=%b",
                   out_data, out_last, out_crc_ok, out_crc_err, out_len_err,
                   e.d, e.last, e.ok, e.err, e.len);
        end
      end
    end
  end

  task automatic send_beat(input logic [15:0] d, input logic last,
                           input logic ok, input logic err, input logic len);
    logic r;
    int   t;
    beat_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t = 0;
    r = 1'b0;
    forever begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      t++;
      if (t > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: in_ready=%b, want 1 within 200 cycles", in_ready);
        break;
      end
    end
    if (r) begin
      e.d = d; e.last = last; e.ok = ok; e.err = err; e.len = len;
      sb.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] crc_word, input logic ok, input logic len);
    foreach (pl[i]) send_beat(pl[i], 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(crc_word, 1'b1, ok, ~ok, len);
  endtask

  task automatic drain();
    int t;
    out_ready = 1'b1;
    rnd_ready = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats outstanding, want 0", sb.size());
    end
  endtask

  task automatic wait_ready_after_reset();
    int t;
    t = 0;
    while (!in_ready && t < 10) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({in_ready, out_valid, out_data, out_last, out_crc_ok, out_crc_err, out_len_err} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b v=%b d=%h l=%b ok=%b err=%b len=%b, want all 0",
               in_ready, out_valid, out_data, out_last, out_crc_ok, out_crc_err, out_len_err);
    end
    n_chk++;
    if (crc_calc !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_crc: crc_calc=%h, want 0000", crc_calc);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready_after_reset();
  endtask

  task automatic test_basic();
    send_beat(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (crc_calc !== 16'h1021) begin
      n_fail++;
      $display("FAIL basic_crc_beat1: crc_calc=%h, want 1021", crc_calc);
    end
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 16'h0001) begin
      n_fail++;
      $display("FAIL basic_latency: out_valid=%b out_data=%h, want 1 0001", out_valid, out_data);
    end
    send_beat(16'h1021, 1'b1, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (crc_calc !== 16'h0000) begin
      n_fail++;
      $display("FAIL basic_crc_reinit: crc_calc=%h, want 0000", crc_calc);
    end
    drain();
  endtask

  task automatic test_crc_cases();
    pl = '{16'h0001, 16'h0002};
    send_frame(16'h1772, 1'b1, 1'b0);
    send_frame(16'h1773, 1'b0, 1'b0);
    pl = {};
    send_frame(16'h0000, 1'b1, 1'b0);
    send_frame(16'h0001, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_length();
    logic [15:0] c;
    // Exactly MAX_WORDS payload words is still legal.
    pl = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    c = 16'h0000;
    foreach (pl[i]) c = model_step(c, pl[i]);
    send_frame(c, 1'b1, 1'b0);
    pl = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
    send_frame(16'h1234, 1'b0, 1'b1);
    pl = '{16'h0001};
    send_frame(16'h1021, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_stall();
    logic [15:0] c;
    out_ready = 1'b1;
    send_beat(16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h5555;
    in_last   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'hAAAA || out_last !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: rdy=%b v=%b d=%h l=%b, want 0 1 aaaa 0",
                 in_ready, out_valid, out_data, out_last);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_beat(16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    c = model_step(model_step(16'h0000, 16'hAAAA), 16'h5555);
    send_beat(c, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] c, cw;
    logic        len, ok;
    int          n;
    rnd_ready = 1'b1;
    for (int f = 0; f < 16; f++) begin
      n = $urandom_range(0, 6);
      pl = {};
      c = 16'h0000;
      len = 1'b0;
      for (int i = 0; i < n; i++) begin
        pl.push_back(16'($urandom));
        if (i < TB_MAX) c = model_step(c, pl[i]);
        else len = 1'b1;
      end
      cw = $urandom_range(0, 1) ? c : (c ^ 16'(1 << $urandom_range(0, 15)));
      ok = !len && (cw == c);
      send_frame(cw, ok, len);
    end
    drain();
  endtask

  task automatic test_reset_midframe();
    out_ready = 1'b1;
    send_beat(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    n_chk++;
    if (out_valid !== 1'b0 || crc_calc !== 16'h0000 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: v=%b crc=%h rdy=%b, want 0 0000 0", out_valid, crc_calc, in_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready_after_reset();
    pl = '{16'h0001};
    send_frame(16'h1021, 1'b1, 1'b0);
    drain();
`ifdef CRC_CHECK_STATS_EN
    n_chk++;
    if (frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_after_reset: frame_cnt=%0d err_cnt=%0d, want 1 0", frame_cnt, err_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_crc_cases();
    test_length();
    test_stall();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 2ms");
    $fatal(1);
  end

endmodule
